if_fetch_queue: RTL
===================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC/address width in bits.
REQ-002 The block SHALL have parameter INST_W, default 32, meaning instruction width in bits.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h00000000, meaning PC value loaded on reset.
REQ-004 The block SHALL have parameter PC_STEP, default 4, meaning sequential PC increment.
REQ-005 The block SHALL have parameter FQ_DEPTH, default 4, meaning fetch queue entries; legal values are powers of two and at least 2.
REQ-006 The block SHALL have a single clock and a synchronous, active-high reset (clk, rst).
REQ-007 The block SHALL have these ports:
  clk  input  1  clock, all state on rising edge
  rst  input  1  synchronous active-high reset
  pc_en  input  1  fetch enable; 0 = hold PC, issue nothing
  redirect_valid  input  1  jump/branch redirect request
  redirect_addr  input  ADDR_W  redirect target
  imem_req  output  1  instruction memory read strobe
  imem_addr  output  ADDR_W  read address, equal to the current PC register
  imem_rdata  input  INST_W  read data, valid the cycle after imem_req
  out_valid  output  1  head of queue holds an instruction
  out_ready  input  1  consumer accepts head
  out_inst  output  INST_W  head instruction
  out_pc  output  ADDR_W  PC of head instruction
  fq_count  output  $clog2(FQ_DEPTH+1)  occupied entries

Function
REQ-008 The block SHALL compute imem_req = pc_en & ~redirect_valid & ~rst & ((fq_count + inflight) < FQ_DEPTH), where inflight is a 1-bit register set when a request issued in the previous cycle.
REQ-009 On each issue, the block SHALL set pc <= pc + PC_STEP, modulo 2^ADDR_W, so that wrap from all-ones to 0 is legal.
REQ-010 The block SHALL record the issued address as a tag and push {imem_rdata, tag} into the queue one cycle after issue, unless that response has been killed.
REQ-011 Issue-to-out_valid latency into an empty queue SHALL be 2 cycles: request at cycle N, push at edge ending cycle N+1, out_valid high in cycle N+2.
REQ-012 out_valid SHALL equal (fq_count != 0); out_inst and out_pc SHALL be driven from the head entry; a pop occurs when out_valid & out_ready are high at the rising edge.
REQ-013 Simultaneous push and pop SHALL leave fq_count unchanged; the credit rule in REQ-008 guarantees no push occurs while the queue is full, and an implementation SHALL assert this in simulation.
REQ-014 With out_ready held high and pc_en high, the block SHALL sustain one instruction per cycle in steady state.
REQ-015 When redirect_valid is high, at that edge the block SHALL:
  - set pc <= redirect_addr;
  - empty the queue (fq_count <= 0);
  - kill the inflight response so it is never pushed;
  - issue nothing in that cycle.
REQ-016 Redirect SHALL take effect regardless of pc_en.
REQ-017 If a pop handshake coincides with redirect, the popped entry SHALL count as delivered and the remaining entries SHALL be discarded.
REQ-018 Back-to-back redirects SHALL each override the previous one; only the last target is fetched.
REQ-019 When pc_en is low, the block SHALL hold the PC and issue nothing; an inflight response SHALL still be pushed, and the queue SHALL still drain.
REQ-020 While out_ready is low, the queue SHALL fill to FQ_DEPTH and then stop issuing; no entry SHALL be lost or duplicated.

Reset
REQ-021 While rst is high at a rising edge, the block SHALL set pc = RESET_PC, fq_count = 0, inflight = 0, and the queue pointers to 0.
REQ-022 During and immediately after reset, outputs SHALL be out_valid = 0, imem_req = 0, and imem_addr = RESET_PC.
REQ-023 Reset asserted mid-operation SHALL discard the queue and any inflight response within the same edge.
REQ-024 The first request after reset SHALL be at RESET_PC, in the first cycle with rst low and pc_en high.

Verification
REQ-025 Scenario: reset, then pc_en = 1 and out_ready = 1, with memory returning inst = addr -> out_pc sequence 0x00, 0x04, 0x08 …; first out_valid 2 cycles after the first request; then 1 instruction per cycle.
REQ-026 Scenario: out_ready = 0 for 10 cycles, then 1 -> fq_count saturates at 4 and imem_req drops; the output then delivers 0x00, 0x04, 0x08, 0x0C with no gaps or duplicates.
REQ-027 Scenario: redirect to 0x04, then to 0x24, then to 0x40 on three consecutive cycles -> no instruction from the old stream or from 0x04/0x24 is output; the next out_pc values are 0x40, 0x44.
REQ-028 Scenario: redirect in the same cycle as a pop -> the popped instruction is delivered; the next out_pc is redirect_addr; fq_count is 0 after the edge.
REQ-029 Scenario: pc_en = 0 for 3 cycles mid-stream -> PC holds; the single inflight instruction is still queued; the sequence resumes without a skip.
REQ-030 Scenario: RESET_PC = 0xFFFFFFF8 -> out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; rst asserted mid-stream -> out_valid = 0 on the next cycle, then restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: sequential PC fetch with credit-limited request issue, redirect kill and an in-order response queue
module if_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4,
  parameter int FQ_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pc_en,
  input  logic redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic out_valid,
  input  logic out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);
  localparam int CW = $clog2(FQ_DEPTH+1);
  localparam int AW = $clog2(FQ_DEPTH);
  logic [ADDR_W-1:0] r_pc, r_tag;
  logic r_inflight;
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic [INST_W-1:0] r_inst [FQ_DEPTH];
  logic [ADDR_W-1:0] r_qpc [FQ_DEPTH];
  logic [CW:0] w_used;
  logic w_req, w_push, w_pop;
  // queued entries plus the response still on its way must leave a free slot
  assign w_used = {1'b0, r_count} + (CW+1)'(r_inflight);
  assign w_req = pc_en & ~redirect_valid & ~rst & (w_used < (CW+1)'(FQ_DEPTH));
  assign w_push = r_inflight & ~redirect_valid & ~rst;
  assign w_pop = out_valid & out_ready;
  assign imem_req = w_req;
  assign imem_addr = r_pc;
  assign out_valid = r_count != '0;
  assign out_inst = r_inst[r_rp];
  assign out_pc = r_qpc[r_rp];
  assign fq_count = r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_pc <= redirect_addr;
      r_inflight <= 1'b0;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      r_inflight <= w_req;
      r_pc <= w_req ? r_pc + ADDR_W'(PC_STEP) : r_pc;
      r_wp <= w_push ? r_wp + AW'(1) : r_wp;
      r_rp <= w_pop ? r_rp + AW'(1) : r_rp;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_req) r_tag <= r_pc;
    if (w_push) begin
      r_inst[r_wp] <= imem_rdata;
      r_qpc[r_wp] <= r_tag;
    end
  end
  always_ff @(posedge clk)
    if (!rst) assert (!(w_push && r_count == CW'(FQ_DEPTH)));
endmodule
